// File: rtl/dsec_feeder.sv
// dsec_feeder: packs 32-bit host word pairs into 64-bit blocks, tags key blocks, queues them for dsec.
// Latency: second half-word at edge t -> in_valid pulse for cycle t+1..t+2 when rdy is high at t+1.
// Backpressure: host_ready drops while the FIFO holds DEPTH blocks; optional zero-pad via DSEC_FEEDER_ZERO_PAD_EN.

module dsec_feeder_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
endmodule

module dsec_feeder #(
  parameter int KEY_WORDS = 3,
  parameter int DEPTH     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_start,
  input  logic [31:0] i_host_data,
  input  logic        i_host_valid,
  input  logic        i_host_last,
  output logic        o_host_ready,
  output logic [63:0] o_data_in,
  output logic        o_key_config,
  output logic        o_in_valid,
  input  logic        i_rdy,
  output logic        o_err
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int KCW = $clog2(2*KEY_WORDS+1);
  localparam logic [KCW-1:0] KEY_LAST = KCW'(2*KEY_WORDS-1);

  typedef enum logic [1:0] {ST_IDLE, ST_KEY, ST_DATA} state_t;

  typedef struct packed {
    logic        key;
    logic [63:0] blk;
  } blk_t;

  state_t         r_state;
  logic [KCW-1:0] r_key_cnt;
  logic           r_half_vld;
  logic [31:0]    r_half;
  logic           r_err;
  logic           r_in_valid;
  logic [63:0]    r_data_in;
  logic           r_key_config;

  logic           w_host_ready;
  logic           w_xfer;
  logic           w_pop;
  logic           w_push;
  blk_t           w_push_dat;
  blk_t           w_head;
  logic [CW-1:0]  w_count;
  logic           w_cfg_enter;

  assign w_host_ready = (r_state != ST_IDLE) && (w_count < CW'(DEPTH));
  assign w_xfer       = i_host_valid && w_host_ready;
  assign w_pop        = (w_count != '0) && i_rdy && !r_in_valid;
  // A cfg_start honoured in DATA takes precedence over any word accepted at the same edge.
  assign w_cfg_enter  = (r_state == ST_DATA) && i_cfg_start && !r_half_vld;

  always_comb begin
    w_push     = 1'b0;
    w_push_dat = '0;
    case (r_state)
      ST_KEY: begin
        if (w_xfer && !i_host_last && r_half_vld) begin
          w_push     = 1'b1;
          w_push_dat = '{key: 1'b1, blk: {r_half, i_host_data}};
        end
      end
      ST_DATA: begin
        if (w_xfer && !w_cfg_enter) begin
          if (r_half_vld) begin
            w_push     = 1'b1;
            w_push_dat = '{key: 1'b0, blk: {r_half, i_host_data}};
          end
`ifdef DSEC_FEEDER_ZERO_PAD_EN
          else if (i_host_last) begin
            w_push     = 1'b1;
            w_push_dat = '{key: 1'b0, blk: {i_host_data, 32'h0}};
          end
`endif
        end
      end
      default: begin
        w_push     = 1'b0;
        w_push_dat = '0;
      end
    endcase
  end

  dsec_feeder_fifo #(
    .W     ($bits(blk_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_key_cnt  <= '0;
      r_half_vld <= 1'b0;
      r_half     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_start) begin
            r_state    <= ST_KEY;
            r_key_cnt  <= '0;
            r_half_vld <= 1'b0;
          end
        end
        ST_KEY: begin
          if (i_cfg_start) r_err <= 1'b1;
          if (w_xfer) begin
            if (i_host_last) begin
              r_err      <= 1'b1;
              r_half_vld <= 1'b0;
              r_key_cnt  <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_half_vld <= !r_half_vld;
              if (!r_half_vld) r_half <= i_host_data;
              if (r_key_cnt == KEY_LAST) begin
                r_key_cnt <= '0;
                r_state   <= ST_DATA;
              end else begin
                r_key_cnt <= r_key_cnt + KCW'(1);
              end
            end
          end
        end
        ST_DATA: begin
          if (w_cfg_enter) begin
            r_state    <= ST_KEY;
            r_key_cnt  <= '0;
            r_half_vld <= 1'b0;
          end else begin
            if (i_cfg_start) r_err <= 1'b1;
            if (w_xfer) begin
              if (r_half_vld) begin
                r_half_vld <= 1'b0;
              end else if (i_host_last) begin
`ifdef DSEC_FEEDER_ZERO_PAD_EN
                r_half_vld <= 1'b0;
`else
                r_err      <= 1'b1;
`endif
              end else begin
                r_half     <= i_host_data;
                r_half_vld <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue only when the previous pulse has ended, giving at least one idle cycle between blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_valid   <= 1'b0;
      r_data_in    <= '0;
      r_key_config <= 1'b0;
    end else if (w_pop) begin
      r_in_valid   <= 1'b1;
      r_data_in    <= w_head.blk;
      r_key_config <= w_head.key;
    end else begin
      r_in_valid   <= 1'b0;
    end
  end

  assign o_host_ready = w_host_ready;
  assign o_data_in    = r_data_in;
  assign o_key_config = r_key_config;
  assign o_in_valid   = r_in_valid;
  assign o_err        = r_err;
endmodule

// File: doc/dsec_feeder.md
# dsec_feeder

Upstream stage of `dsec`. Accepts a 32-bit host word stream over a valid/ready handshake, packs word pairs into 64-bit blocks, tags the first `KEY_WORDS` blocks after a configuration command as key material, and buffers blocks in a small FIFO. It drives `dsec`'s `data_in`/`key_config`/`in_valid` inputs as single-cycle pulses, gated by `dsec`'s `rdy`.

## Interface
- `KEY_WORDS`, 3: number of 64-bit key blocks loaded per `cfg_start`.
- `DEPTH`, 4: FIFO depth in 65-bit entries (64 data + key flag); power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_start` in 1: one-cycle pulse; begin key load.
- `host_data` in 32: host word.
- `host_valid` in 1: `host_data` valid.
- `host_last` in 1: qualifies final word of a data frame.
- `host_ready` out 1: feeder accepts a host word this cycle.
- `data_in` out 64: block to `dsec`.
- `key_config` out 1: current block is key material.
- `in_valid` out 1: block presented to `dsec`; one-cycle pulse.
- `rdy` in 1: `dsec` ready for a block.
- `err` out 1: one-cycle error pulse.

## Operation
- States: IDLE, KEY, DATA. Reset → IDLE.
- IDLE: `host_ready`=0. `cfg_start` → KEY and clear key block counter.
- KEY: accept 2·`KEY_WORDS` host words. After the last key half-word is accepted → DATA. `host_last` accepted in KEY: `err` pulse, pending half-word discarded, key counter cleared, → IDLE. Blocks already in the FIFO are still delivered.
- DATA: accept words continuously. `host_last` carries no state change other than padding (see Configuration). `cfg_start` → KEY only when no half-word is pending. Otherwise it is ignored and `err` pulses.
- `cfg_start` in KEY is ignored with an `err` pulse.
- Packing: the first accepted word of a pair goes to bits [63:32] (held in the half register), the second to [31:0]. On the second word, the FIFO is written with {key flag, block}. Key flag = 1 iff the block was formed in KEY.
- Host transfer: occurs at an edge where `host_valid`&&`host_ready`. `host_ready` = (state≠IDLE) && (FIFO count < `DEPTH`), using the registered count. A pop in the same cycle does not raise `host_ready` that cycle.
- Output issue: at an edge where FIFO is non-empty, `rdy`=1 and `in_valid`=0, register the head into `data_in`/`key_config`, set `in_valid`=1 and pop. The next edge clears `in_valid`. Consequently there is at least one idle cycle between blocks.
- `data_in`/`key_config` hold their last issued value until the next issue.
- Push and pop at the same edge are legal; the count is unchanged. Pointers wrap modulo `DEPTH`.

## Timing
- Reset values: `host_ready`=0, `in_valid`=0, `data_in`=0, `key_config`=0, `err`=0, FIFO empty, half register empty, state IDLE.
- `rst` mid-operation clears everything above, including FIFO contents and the pending half-word, at the next edge.
- Latency: second half-word accepted at edge t → earliest `in_valid` high for cycle t+1..t+2, provided `rdy`=1 at edge t+1.
- Peak throughput: one block per 2 cycles.
- `rdy` low: blocks accumulate. Once `DEPTH` blocks are stored, `host_ready`=0.
- `err` is registered: high exactly one cycle after the offending edge.

## Configuration
- Macro: `DSEC_FEEDER_ZERO_PAD_EN`.
- Defined: `host_last` accepted on the first half of a pair in DATA → block {word, 32'h0} is pushed immediately with key flag 0, with no `err`.
- Undefined: that half-word is dropped and `err` pulses.
- Either build: `host_last` on the second half is a normal push.

## Test plan
- Reset behaviour: `rst`=1 for 2 cycles with `host_valid`=1 → all outputs at reset values, `host_ready`=0.
- Key load: `cfg_start`, then six words 9474B8E8, C73BCA7D repeated, with `rdy`=1 → three `in_valid` pulses, each with `data_in`=64'h9474B8E8C73BCA7D and `key_config`=1, separated by ≥1 idle cycle; the state then reaches DATA.
- Data backpressure: after key load, `rdy`=0, stream words 0x1..0xA → FIFO fills with 4 blocks and `host_ready` drops; the 5th block is held pending. Raising `rdy` yields blocks 0x00000001_00000002 … 0x00000009_0000000A in order, with `key_config`=0.
- Odd frame end: in DATA, send 0xDEADBEEF with `host_last`=1 → with macro, block 64'hDEADBEEF00000000 and no `err`; without macro, no block and a one-cycle `err`.
- Protocol errors: `host_last` during the 3rd key word → `err` pulse and return to IDLE. `cfg_start` while a half-word is pending in DATA → `err` pulse and the state stays DATA.
- Mid-operation reset: `rst` asserted while 3 blocks are queued and `rdy`=0 → after release, no `in_valid` occurs even once `rdy`=1.
